// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the MCP3002-class SPI ADC sampler.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned PERIOD_W       = 4;
    localparam int unsigned FIRST_DATA_BIT = 6;
    localparam int unsigned DATA_W         = 10;

    // {null, start, single-ended, channel, MSB-first, 11'b0}
    localparam logic [FRAME_BITS-1:0] CMD_BASE   = 16'h6800;
    localparam int unsigned           CMD_CH_BIT = 12;

    function automatic logic [FRAME_BITS-1:0] cmd_word(input logic ch);
        logic [FRAME_BITS-1:0] w;
        w             = CMD_BASE;
        w[CMD_CH_BIT] = ch;
        return w;
    endfunction

endpackage

// File: rtl/adc_spi_sampler_sclk_gen.sv
// Half-period divider: times SETUP/HOLD intervals and paces SCLK edges in SHIFT.
module sclk_gen #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_toggle,
    output logic o_half_end_c,
    output logic o_rise_c,
    output logic o_fall_c
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    assign o_half_end_c = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_rise_c     = o_half_end_c && i_toggle && !r_phase;
    assign o_fall_c     = o_half_end_c && i_toggle && r_phase;

    // Phase only advances while toggling so every SHIFT starts on a low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt <= o_half_end_c ? '0 : r_cnt + CNT_W'(1);
            if (!i_toggle)
                r_phase <= 1'b0;
            else if (o_half_end_c)
                r_phase <= !r_phase;
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI frame engine for an MCP3002-class ADC; emits a 10-bit sample and one-cycle strobe.
module adc_spi_sampler
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 12,
    parameter int unsigned SAMPLE_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              channel,
    input  logic              miso,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun
);
    localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);

    state_t                r_state;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [FRAME_BITS-1:0] r_cmd;
    logic [DATA_W-1:0]     r_rx;
    logic [PERIOD_W-1:0]   r_period;

    logic w_tick;
    logic w_gen_en;
    logic w_gen_toggle;
    logic w_half_end;
    logic w_rise;
    logic w_fall;

    assign w_tick       = (r_tick_cnt == TICK_W'(SAMPLE_DIV - 1));
    assign w_gen_en     = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
    assign w_gen_toggle = (r_state == ST_SHIFT);

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (w_gen_en),
        .i_toggle     (w_gen_toggle),
        .o_half_end_c (w_half_end),
        .o_rise_c     (w_rise),
        .o_fall_c     (w_fall)
    );

    // Free-running sample-rate counter, independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            r_cmd      <= '0;
            r_rx       <= '0;
            r_period   <= '0;
        end else begin
            data_valid <= 1'b0;
            if (w_tick && (r_state != ST_IDLE))
                overrun <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_tick && enable) begin
                        r_state  <= ST_SETUP;
                        cs_n     <= 1'b0;
                        mosi     <= 1'b0;
                        r_cmd    <= cmd_word(channel);
                        r_period <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_half_end) begin
                        r_state <= ST_SHIFT;
                        mosi    <= r_cmd[FRAME_BITS-1];
                        r_cmd   <= r_cmd << 1;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        sclk <= 1'b1;
                        if (r_period >= PERIOD_W'(FIRST_DATA_BIT))
                            r_rx <= {r_rx[DATA_W-2:0], miso};
                    end
                    // Falling edge closes a period; mosi advances only here.
                    if (w_fall) begin
                        sclk <= 1'b0;
                        if (r_period == PERIOD_W'(FRAME_BITS - 1)) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_period <= r_period + PERIOD_W'(1);
                            mosi     <= r_cmd[FRAME_BITS-1];
                            r_cmd    <= r_cmd << 1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_half_end) begin
                        r_state    <= ST_DONE;
                        cs_n       <= 1'b1;
                        data_out   <= r_rx;
                        data_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Randomized bench for adc_spi_sampler against a frame-timing reference model and an SPI ADC model.
module tb_adc_spi_sampler;

    localparam int CD    = 12;
    localparam int SD    = 1024;
    localparam int SD_OV = 300;
    localparam int FR    = 34 * CD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       channel = 1'b0;
    logic       miso = 1'b0;
    logic       sclk, cs_n, mosi, dv, ovr;
    logic [9:0] dout;
    logic       o_sclk, o_cs_n, o_mosi, o_dv, o_ovr;
    logic [9:0] o_dout;

    always #5 clk = ~clk;

    adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .channel(channel), .miso(miso),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .data_out(dout), .data_valid(dv), .overrun(ovr)
    );

    adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_DIV(SD_OV)) dut_ov (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .channel(1'b0), .miso(1'b1),
        .sclk(o_sclk), .cs_n(o_cs_n), .mosi(o_mosi), .data_out(o_dout), .data_valid(o_dv),
        .overrun(o_ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SPI ADC model: mode 0, drives each data bit from the falling edge before its rise.
    logic [9:0]  adc_val;
    logic [9:0]  adc_q[$];
    int          rise_cnt = 0;
    logic [15:0] mosi_bits = '0;
    bit          sclk_q = 1'b0;

    function automatic logic adc_bit(input int p);
        if (p >= 6 && p <= 15) return adc_val[15-p];
        return 1'b0;
    endfunction

    always @(posedge sclk or negedge sclk or negedge cs_n) begin
        if (sclk && !sclk_q) begin
            rise_cnt++;
            mosi_bits = {mosi_bits[14:0], mosi};
        end else if (!sclk && sclk_q) begin
            miso = adc_bit(rise_cnt);
        end else begin
            rise_cnt  = 0;
            mosi_bits = '0;
            miso      = 1'b0;
        end
        sclk_q = sclk;
    end

    // Reference model: one record per DUT holding the current frame's start tick.
    typedef struct {
        bit         busy;
        int         t0;
        bit         ch;
        logic [9:0] val;
        logic [9:0] dout;
        bit         ovr;
    } mdl_t;

    mdl_t m_main, m_ov;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.busy = 0; m.t0 = 0; m.ch = 0; m.val = '0; m.dout = '0; m.ovr = 0;
        return m;
    endfunction

    function automatic bit mdl_done(input mdl_t m, input int c);
        return m.busy && (c == m.t0 + 1 + FR);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int c, input int sd, input bit en,
                                      input bit ch, input logic [9:0] val);
        mdl_t n;
        n = m;
        if (mdl_done(m, c)) begin
            n.busy = 0;
            n.dout = m.val;
        end
        if (c % sd == sd - 1) begin
            if (m.busy) n.ovr = 1;
            else if (en) begin
                n.busy = 1; n.t0 = c; n.ch = ch; n.val = val;
            end
        end
        return n;
    endfunction

    task automatic check_dut(input string p, input mdl_t m, input int c, input logic a_cs,
                             input logic a_sclk, input logic a_dv, input logic a_ovr,
                             input logic [9:0] a_dout);
        bit act;
        int o;
        bit e_cs, e_dv, e_sclk;
        act    = m.busy && (c > m.t0);
        o      = c - (m.t0 + 1 + CD);
        e_cs   = !(act && c <= m.t0 + FR);
        e_dv   = mdl_done(m, c);
        e_sclk = act && o >= 0 && o < 32 * CD && (o % (2 * CD)) >= CD;
        check({p, ".cs_n"}, 32'(a_cs), 32'(e_cs));
        check({p, ".sclk"}, 32'(a_sclk), 32'(e_sclk));
        check({p, ".valid"}, 32'(a_dv), 32'(e_dv));
        check({p, ".overrun"}, 32'(a_ovr), 32'(m.ovr));
        check({p, ".data"}, 32'(a_dout), 32'(e_dv ? m.val : m.dout));
    endtask

    bit en_req   = 1'b0;
    bit ch_req   = 1'b0;
    bit rnd_mode = 1'b0;

    task automatic step();
        @(negedge clk);
        check_dut("main", m_main, cyc, cs_n, sclk, dv, ovr, dout);
        check_dut("ov", m_ov, cyc, o_cs_n, o_sclk, o_dv, o_ovr, o_dout);
        if (mdl_done(m_main, cyc)) begin
            check("main.cmd", 32'(mosi_bits), 32'({1'b0, 1'b1, 1'b1, m_main.ch, 1'b1, 11'b0}));
            check("main.rises", 32'(rise_cnt), 32'd16);
            if (adc_q.size() > 0) adc_val = adc_q.pop_front();
            else adc_val = 10'($urandom);
        end
        if (mdl_done(m_ov, cyc))
            check("ov.mosi_last", 32'(o_mosi), 32'd0);
        if (rnd_mode) begin
            if ($urandom_range(299) == 0) en_req = !en_req;
            if ($urandom_range(49) == 0) ch_req = !ch_req;
        end
        enable  = en_req;
        channel = ch_req;
        m_main  = mdl_step(m_main, cyc, SD, en_req, ch_req, adc_val);
        m_ov    = mdl_step(m_ov, cyc, SD_OV, 1'b1, 1'b0, 10'h3FF);
        cyc++;
    endtask

    task automatic run_until_rises(input int n, input int max_cyc);
        int i;
        i = 0;
        while (!(cs_n === 1'b0 && rise_cnt >= n) && i < max_cyc) begin
            step();
            i++;
        end
        check("wait_frame", 32'(cs_n === 1'b0 && rise_cnt >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, ".rst_cs_n"}, 32'(cs_n), 32'd1);
        check({p, ".rst_sclk"}, 32'(sclk), 32'd0);
        check({p, ".rst_mosi"}, 32'(mosi), 32'd0);
        check({p, ".rst_data"}, 32'(dout), 32'd0);
        check({p, ".rst_valid"}, 32'(dv), 32'd0);
        check({p, ".rst_ovr"}, 32'(ovr), 32'd0);
        check({p, ".rst_ov_cs_n"}, 32'(o_cs_n), 32'd1);
        check({p, ".rst_ov_ovr"}, 32'(o_ovr), 32'd0);
    endtask

    initial begin
        adc_val = 10'h2A5;
        adc_q   = {10'h3FF, 10'h000};
        m_main  = mdl_reset();
        m_ov    = mdl_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        // Release; the cycle up to the next edge is counter value 0.
        rst_n  = 1'b1;
        en_req = 1'b1;
        enable = 1'b1;
        cyc    = 1;

        repeat (1500) step();             // single frame, channel 0, 0x2A5
        ch_req = 1'b1;
        repeat (2100) step();             // channel 1, 0x3FF then 0x000

        run_until_rises(3, 1200);         // enable dropped mid-frame
        en_req = 1'b0;
        repeat (2600) step();
        en_req = 1'b1;
        repeat (1500) step();

        rnd_mode = 1'b1;
        repeat (6000) step();
        rnd_mode = 1'b0;
        en_req   = 1'b1;

        run_until_rises(9, 2100);         // async reset during SCLK period 8
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        m_main = mdl_reset();
        m_ov   = mdl_reset();
        repeat (2) @(negedge clk);
        check("mid.no_valid", 32'(dv), 32'd0);
        rst_n = 1'b1;
        cyc   = 1;
        repeat (2200) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

- Periodically reads one 10-bit sample from an external MCP3002-class SPI ADC and presents it as a 10-bit word with a one-cycle strobe.
- Sits directly upstream of the PWM DAC stage: `data_out` drives the PWM `data_in` and `data_valid` drives its `load`.
- Sets the audio/control sample rate for the datapath and owns the SPI pins (`sclk`, `cs_n`, `mosi`, `miso`).

## Interface
Parameters:
- `CLK_DIV`, 12: `clk` cycles per SCLK half-period (SCLK = f_clk / (2·CLK_DIV)); must be ≥ 2.
- `SAMPLE_DIV`, 1024: `clk` cycles between sample ticks; legal configuration requires `SAMPLE_DIV` ≥ 34·CLK_DIV + 2.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new frames to start at a sample tick.
- `channel`  in  1  ADC channel select; latched at frame start.
- `miso`  in  1  ADC serial data out.
- `sclk`  out  1  SPI clock, mode 0 (idle low).
- `cs_n`  out  1  ADC chip select, active low.
- `mosi`  out  1  command bit to the ADC.
- `data_out`  out  10  last completed sample; holds between frames.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates; connects to PWM `load`.
- `overrun`  out  1  sticky flag: a sample tick arrived while a frame was in progress.

## Operation
- **Tick counter:** free-running, 0..SAMPLE_DIV-1. The tick fires when the count equals SAMPLE_DIV-1, then the counter wraps to 0. It runs regardless of `enable`.
- **Frame start:** a tick in IDLE with `enable`=1 starts a frame. A tick in IDLE with `enable`=0 is ignored. A tick in any other state is dropped and sets `overrun`=1, which stays set until reset.
- **States:**
  - IDLE → SETUP on tick && enable.
  - SETUP: `cs_n`=0, `sclk`=0 for CLK_DIV cycles → SHIFT.
  - SHIFT: 16 SCLK periods, low half first, then high half → HOLD after the 16th high half.
  - HOLD: `sclk`=0, `cs_n`=0 for CLK_DIV cycles → DONE.
  - DONE: `cs_n`=1, `data_out` loaded, `data_valid`=1 for one cycle → IDLE.
- **Command word:** latched at the IDLE→SETUP transition as {0, 1 (start), 1 (single-ended), channel, 1 (MSB-first), 11'b0}. Bit 15 is on `mosi` during SCLK period 0, bit 0 during period 15. `mosi` changes only at the start of a low half.
- **Capture:** `miso` is sampled on the `clk` cycle in which `sclk` rises, for SCLK periods 6..15 only (MSB first) into a 10-bit shift register. Periods 0..5 are ignored (command plus null bit).
- **Output hold:** `data_out` is unsigned with no arithmetic. It changes only in DONE.
- **`enable` deasserted mid-frame:** the frame completes normally and no further frames start.
- **`channel` changed mid-frame:** no effect until the next frame.

## Timing
- **Reset values (async on `rst_n`=0, immediate, mid-frame included):**
  - `cs_n`=1, `sclk`=0, `mosi`=0
  - `data_out`=0, `data_valid`=0, `overrun`=0
  - state IDLE, tick counter 0, divider 0
  - A frame in progress is aborted and produces no `data_valid`.
- **Latency:** the tick cycle is T. `cs_n` falls at T+1. The first `sclk` rise is at T+1+2·CLK_DIV. `data_valid` is high at T+1+34·CLK_DIV (T+409 at defaults). `data_out` is valid in the same cycle as `data_valid`.
- **Frame duration:** `cs_n` is low for exactly 34·CLK_DIV cycles.
- **Sample rate:** one `data_valid` every SAMPLE_DIV cycles in steady state. At 50 MHz with defaults this is ≈48.8 kHz.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Package `adc_spi_pkg`:**
  - state typedef: IDLE, SETUP, SHIFT, HOLD, DONE
  - `FRAME_BITS`=16
  - `FIRST_DATA_BIT`=6
  - `DATA_W`=10
  - command-word constant with the channel bit position
- **Sub-module `sclk_gen`:** CLK_DIV half-period divider. It emits single-cycle `rise` and `fall` enables and a half-period counter, and is also used for the SETUP and HOLD intervals.
- **Top level:** the FSM, the tick counter, the MOSI shift register and the MISO shift register.

## Test plan
1. **Single frame:** reset, `enable`=1, `channel`=0, ADC model returns 10'h2A5 → `mosi` bits 0,1,1,0,1,0…; `data_out`=10'h2A5 with `data_valid` exactly one cycle at T+409; `cs_n` low 408 cycles.
2. **Channel select:** `channel`=1, model returns 10'h3FF then 10'h000 on consecutive frames → `mosi` bit 12 = 1; `data_out` 10'h3FF then 10'h000; `data_valid` pulses 1024 cycles apart.
3. **Enable gating:** drop `enable` in mid-frame → that frame completes with `data_valid`; no `cs_n` activity afterwards. Reassert → next frame starts on the next tick, not immediately.
4. **Async reset mid-frame:** assert `rst_n`=0 at SCLK period 8 → `cs_n`=1 and `sclk`=0 the same cycle; no `data_valid`; `data_out`=0; restart after release is clean.
5. **Overrun:** SAMPLE_DIV=300, CLK_DIV=12 → `overrun` rises at the second tick and stays 1; every other tick yields a frame; `data_valid` spacing is 600 cycles.
6. **PWM integration:** connect to the PWM stage, model returns 10'd512 → PWM `d` loads 512 on the `data_valid` cycle; PWM duty ≈50%.
